grf_write_arbiter: RTL and testbench
====================================

# grf_write_arbiter

Writer-side front end for the general register file: merges register-write requests from the main pipeline writeback path and from a multi-cycle execution unit (mult/div, HI/LO moves) onto the register file's single write port. Pipeline writes take priority. Multi-cycle results are buffered in a small FIFO and drained in idle write slots. A forwarding query port exposes buffered-but-uncommitted writes to the hazard unit.

## Interface
Parameters:
- DEPTH, 4, FIFO entries for the multi-cycle channel; power of two, 2..16.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- p_valid  in  1  pipeline write request this cycle; always accepted, no ready.
- p_wa  in  5  pipeline destination register.
- p_wd  in  32  pipeline write data.
- p_pc  in  32  PC of the producing instruction.
- m_valid  in  1  multi-cycle unit request.
- m_ready  out  1  FIFO can accept; equals (count != DEPTH), independent of m_valid.
- m_wa  in  5  multi-cycle destination register.
- m_wd  in  32  multi-cycle write data.
- m_pc  in  32  PC of the producing instruction.
- reg_write  out  1  register-file write enable, registered.
- wa  out  5  register-file write address, registered.
- wd  out  32  register-file write data, registered.
- wpc  out  32  PC of the committing write, registered.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- q_addr  in  5  forwarding query address.
- q_hit  out  1  a FIFO entry targets q_addr (q_addr != 0).
- q_data  out  32  data of the youngest matching FIFO entry; 0 when no hit.

## Operation
- Each cycle, exactly one source drives the output register:
  - p_valid=1: load {1, p_wa, p_wd, p_pc}.
  - else FIFO non-empty: pop the head and load {1, head}.
  - else: load reg_write=0; wa/wd/wpc hold their previous values.
- Push: m_valid && m_ready writes {m_wa, m_wd, m_pc} at the tail.
- Push and pop in the same cycle are allowed; count is unchanged.
- Push into an empty FIFO is not popped the same cycle; first possible commit is the next cycle.
- Full FIFO: m_ready=0; m_valid ignored; the producer holds its request.
- Sustained p_valid starves the FIFO by design. The hazard unit uses m_ready/count to insert bubbles.
- Writes to register 0 pass through with reg_write=1; the register file discards them.
- No reordering: the pipeline write wins the slot. Program-order hazards between the channels are resolved by the hazard unit stalling on q_hit.
- q_hit/q_data are combinational over valid FIFO entries only. The output register is not included; the register file's read path covers it. Youngest means closest to the tail.
- Pointers are $clog2(DEPTH) bits, wrap modulo DEPTH; full/empty are derived from count.

## Timing
- Latency: request cycle N commits on reg_write at cycle N+1 (pipeline write, or pop of a non-empty FIFO).
- FIFO entry latency: minimum 2 cycles from push to commit.
- Reset (cycle edge with reset=1): reg_write=0, wa=0, wd=0, wpc=0, count=0, pointers=0, m_ready=1 from the following cycle.
- Reset mid-operation: buffered entries are discarded; a push in the reset cycle is dropped.
- Throughput: one commit per cycle.

## Configuration
- GRF_WRITE_TRACE_EN defined: each cycle with reg_write=1 at the clock edge prints "@%h: $%d <= %h" with wpc, wa, wd. This includes register 0, so the log matches the register file's write log line for line.
- Not defined: no simulation output; RTL otherwise identical.

## Structure
- Package grf_pkg holds:
  - typedef wb_req_t {logic [4:0] wa; logic [31:0] wd; logic [31:0] pc;}
  - constant REG_ZERO = 5'd0
  - constant DATA_W = 32
- Sub-module grf_wb_fifo (DEPTH-parameterised, synchronous, with a parallel entry-compare port for the query) holds the storage and pointers. The top holds the arbiter and the output register.

## Test plan
- Reset: assert reset 2 cycles while m_valid=1 -> reg_write=0, count=0, m_ready=1, q_hit=0 afterwards.
- Pipeline only: p_valid with wa=5, wd=0x1234, pc=0x3000 in cycle N -> reg_write=1, wa=5, wd=0x1234, wpc=0x3000 in N+1. Idle cycle -> reg_write=0.
- Buffering and priority: push m {wa=8, wd=0xAA} while p_valid is held for 3 cycles -> three pipeline commits, then wa=8/0xAA commits in the next cycle; count goes 1 -> 0.
- Full FIFO (DEPTH=4): 4 pushes under continuous p_valid -> count=4, m_ready=0; a 5th m_valid is not accepted. Drop p_valid -> entries commit in push order over 4 cycles.
- Forwarding: FIFO holds wa=9/0x11 then wa=9/0x22 -> q_addr=9 gives q_hit=1, q_data=0x22. q_addr=0 gives q_hit=0.
- Simultaneous push/pop and wrap: 10 back-to-back pushes with p_valid=0 -> one commit per cycle in order, count never exceeds 1, pointers wrap cleanly.

Source files
------------

// File: rtl/grf_write_arbiter_pkg.sv
// grf_write_arbiter_pkg: shared types and constants for the register-file write path (package grf_pkg)
package grf_pkg;
    localparam int DATA_W = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;
    typedef struct packed {
        logic [4:0]        wa;
        logic [DATA_W-1:0] wd;
        logic [DATA_W-1:0] pc;
    } wb_req_t;
endpackage

// File: rtl/grf_write_arbiter_if.sv
// grf_write_arbiter_if: pipeline/multi-cycle request, register-file write and forwarding query signals
interface grf_write_arbiter_if #(parameter int DEPTH = 4);
    import grf_pkg::*;
    localparam int CW = $clog2(DEPTH) + 1;
    logic              p_valid;
    logic [4:0]        p_wa;
    logic [DATA_W-1:0] p_wd;
    logic [DATA_W-1:0] p_pc;
    logic              m_valid;
    logic              m_ready;
    logic [4:0]        m_wa;
    logic [DATA_W-1:0] m_wd;
    logic [DATA_W-1:0] m_pc;
    logic              reg_write;
    logic [4:0]        wa;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] wpc;
    logic [CW-1:0]     count;
    logic [4:0]        q_addr;
    logic              q_hit;
    logic [DATA_W-1:0] q_data;
    modport master (
        output p_valid, p_wa, p_wd, p_pc, m_valid, m_wa, m_wd, m_pc, q_addr,
        input  m_ready, reg_write, wa, wd, wpc, count, q_hit, q_data
    );
    modport slave (
        input  p_valid, p_wa, p_wd, p_pc, m_valid, m_wa, m_wd, m_pc, q_addr,
        output m_ready, reg_write, wa, wd, wpc, count, q_hit, q_data
    );
endinterface

// File: rtl/grf_write_arbiter_wb_fifo.sv
// grf_wb_fifo: multi-cycle write buffer with occupancy count and youngest-match forwarding compare
module grf_wb_fifo
    import grf_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  wb_req_t           push_data,
    input  logic              pop,
    output wb_req_t           head,
    output logic [CW-1:0]     count,
    output logic              full,
    output logic              empty,
    input  logic [4:0]        q_addr,
    output logic              q_hit,
    output logic [DATA_W-1:0] q_data
);
    wb_req_t       mem_q [DEPTH];
    wb_req_t       mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, idx;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Next storage, pointer and occupancy state; full/empty come from the count alone
    always_comb begin
        mem_d = mem_q;
        if (do_push) mem_d[wr_ptr_q] = push_data;
        wr_ptr_d = wr_ptr_q + PW'(do_push);
        rd_ptr_d = rd_ptr_q + PW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointers and count reset; a push during reset is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: only slots covered by count are ever read
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Scan valid entries oldest to youngest so the last match (closest to tail) wins
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        idx    = rd_ptr_q;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr_q + PW'(k);
            if (CW'(k) < count_q && q_addr != REG_ZERO && mem_q[idx].wa == q_addr) begin
                q_hit  = 1'b1;
                q_data = mem_q[idx].wd;
            end
        end
    end
endmodule

// File: rtl/grf_write_arbiter.sv
// grf_write_arbiter: merges pipeline and buffered multi-cycle writes onto one register-file write port (trace: GRF_WRITE_TRACE_EN)
module grf_write_arbiter
    import grf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    grf_write_arbiter_if.slave bus
);
    wb_req_t           m_req, head;
    logic              full, empty;
    logic              reg_write_q, reg_write_d;
    logic [4:0]        wa_q, wa_d;
    logic [DATA_W-1:0] wd_q, wd_d, wpc_q, wpc_d;

    assign m_req = '{wa: bus.m_wa, wd: bus.m_wd, pc: bus.m_pc};

    grf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.m_valid),
        .push_data (m_req),
        .pop       (!bus.p_valid),
        .head      (head),
        .count     (bus.count),
        .full      (full),
        .empty     (empty),
        .q_addr    (bus.q_addr),
        .q_hit     (bus.q_hit),
        .q_data    (bus.q_data)
    );

    assign bus.m_ready   = !full;
    assign bus.reg_write = reg_write_q;
    assign bus.wa        = wa_q;
    assign bus.wd        = wd_q;
    assign bus.wpc       = wpc_q;

    // Pipeline owns the slot; otherwise drain the FIFO head; otherwise idle and hold address/data
    always_comb begin
        reg_write_d = bus.p_valid || !empty;
        wa_d        = bus.p_valid ? bus.p_wa : !empty ? head.wa : wa_q;
        wd_d        = bus.p_valid ? bus.p_wd : !empty ? head.wd : wd_q;
        wpc_d       = bus.p_valid ? bus.p_pc : !empty ? head.pc : wpc_q;
    end

    // Registered write port
    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_q <= 1'b0;
            wa_q        <= '0;
            wd_q        <= '0;
            wpc_q       <= '0;
        end else begin
            reg_write_q <= reg_write_d;
            wa_q        <= wa_d;
            wd_q        <= wd_d;
            wpc_q       <= wpc_d;
        end
    end

`ifdef GRF_WRITE_TRACE_EN
    // Commit log, register 0 included so it lines up with the register file's own log
    always_ff @(posedge clk) begin
        if (reg_write_q) $display("@%h: $%d <= %h", wpc_q, wa_q, wd_q);
    end
`endif
endmodule

// File: tb/tb_grf_write_arbiter.sv
// tb_grf_write_arbiter: randomized + directed scoreboard bench against a queue-based reference model
module tb_grf_write_arbiter;
    import grf_pkg::*;
    localparam int DEPTH = 4;

    typedef struct {
        logic        rw;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [31:0] pc;
        int          cnt;
        logic        rdy;
        logic        hit;
        logic [31:0] qd;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    exp_t exp_q[$];
    wb_req_t fifo_m[$];
    logic [4:0] last_wa = '0;
    logic [31:0] last_wd = '0;
    logic [31:0] last_pc = '0;

    grf_write_arbiter_if #(.DEPTH(DEPTH)) bus ();
    grf_write_arbiter #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Drive one cycle's inputs at the falling edge and record what the model expects after the next rising edge
    task automatic drv(input bit r, input bit pv, input logic [4:0] pwa, input logic [31:0] pwd, input logic [31:0] ppc,
                       input bit mv, input logic [4:0] mwa, input logic [31:0] mwd, input logic [31:0] mpc,
                       input logic [4:0] qa);
        exp_t e;
        int pre;
        wb_req_t c;
        @(negedge clk);
        reset = r;
        bus.p_valid = pv; bus.p_wa = pwa; bus.p_wd = pwd; bus.p_pc = ppc;
        bus.m_valid = mv; bus.m_wa = mwa; bus.m_wd = mwd; bus.m_pc = mpc;
        bus.q_addr = qa;
        if (r) begin
            fifo_m.delete();
            last_wa = '0; last_wd = '0; last_pc = '0;
            e.rw = 1'b0;
        end else begin
            pre = fifo_m.size();
            e.rw = pv || pre > 0;
            if (pv) begin
                last_wa = pwa; last_wd = pwd; last_pc = ppc;
            end else if (pre > 0) begin
                c = fifo_m.pop_front();
                last_wa = c.wa; last_wd = c.wd; last_pc = c.pc;
            end
            if (mv && pre < DEPTH) fifo_m.push_back('{wa: mwa, wd: mwd, pc: mpc});
        end
        e.wa = last_wa; e.wd = last_wd; e.pc = last_pc;
        e.cnt = fifo_m.size();
        e.rdy = fifo_m.size() != DEPTH;
        e.hit = 1'b0; e.qd = '0;
        for (int i = fifo_m.size() - 1; i >= 0; i--) begin
            if (qa != 5'd0 && fifo_m[i].wa == qa) begin
                e.hit = 1'b1; e.qd = fifo_m[i].wd;
                break;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [4:0] qa);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, qa);
    endtask

    // Monitor: compare DUT state just after each rising edge with the oldest outstanding expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("reg_write", 32'(bus.reg_write), 32'(e.rw));
                chk("wa", 32'(bus.wa), 32'(e.wa));
                chk("wd", bus.wd, e.wd);
                chk("wpc", bus.wpc, e.pc);
                chk("count", 32'(bus.count), e.cnt);
                chk("m_ready", 32'(bus.m_ready), 32'(e.rdy));
                chk("q_hit", 32'(bus.q_hit), 32'(e.hit));
                chk("q_data", bus.q_data, e.qd);
            end
        end
    end

    initial begin
        bus.p_valid = 0; bus.p_wa = 0; bus.p_wd = 0; bus.p_pc = 0;
        bus.m_valid = 0; bus.m_wa = 0; bus.m_wd = 0; bus.m_pc = 0; bus.q_addr = 0;
        // reset while the multi-cycle unit is requesting
        drv(1, 0, 0, 0, 0, 1, 3, 32'h55, 32'h100, 3);
        drv(1, 0, 0, 0, 0, 1, 3, 32'h55, 32'h100, 3);
        // pipeline only, then idle
        drv(0, 1, 5, 32'h1234, 32'h3000, 0, 0, 0, 0, 0);
        idle(0);
        // buffering behind three pipeline writes
        drv(0, 1, 1, 32'h101, 32'h4000, 1, 8, 32'hAA, 32'h5000, 8);
        drv(0, 1, 2, 32'h102, 32'h4004, 0, 0, 0, 0, 8);
        drv(0, 1, 3, 32'h103, 32'h4008, 0, 0, 0, 0, 8);
        idle(8);
        idle(0);
        // fill to DEPTH under continuous pipeline traffic; fifth push is refused
        for (int i = 0; i < 5; i++)
            drv(0, 1, 5'(20 + i), 32'(i), 32'h6000 + 32'(4 * i), 1, 5'(10 + i), 32'hB0 + 32'(i), 32'h7000 + 32'(4 * i), 5'(10 + i));
        for (int i = 0; i < 5; i++) idle(5'(11 + i));
        // forwarding: youngest of two entries for the same register
        drv(0, 1, 1, 32'h1, 32'h8000, 1, 9, 32'h11, 32'h8100, 9);
        drv(0, 1, 2, 32'h2, 32'h8004, 1, 9, 32'h22, 32'h8104, 9);
        drv(0, 1, 3, 32'h3, 32'h8008, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) idle(9);
        // back-to-back pushes with no pipeline traffic wrap the pointers
        for (int i = 0; i < 10; i++)
            drv(0, 0, 0, 0, 0, 1, 5'(i + 1), 32'hC00 + 32'(i), 32'h9000 + 32'(4 * i), 5'(i + 1));
        idle(0);
        idle(0);
        // randomized traffic with occasional reset
        for (int i = 0; i < 3000; i++)
            drv($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom, $urandom,
                $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom_range(0, 7)));
        idle(0);
        @(negedge clk);
        @(negedge clk);
        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
